// File: rtl/adder_measure_sequencer.sv
// Sequences one adder-delay measurement: load operands, settle, count ring-oscillator edges for a window, drain, report.
// Latency: done rises SETTLE_CYCLES+cfg_window+5 cycles after start is sampled; no backpressure, start is ignored while busy.
module adder_measure_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned COUNT_W       = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               active,
  input  logic               start,
  input  logic [31:0]        cfg_a,
  input  logic [31:0]        cfg_b,
  input  logic [31:0]        cfg_window,
  input  logic               chain_out,
  output logic [31:0]        a_input,
  output logic [31:0]        b_input,
  output logic               ring_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic               sync_q1;
  logic               sync_q2;
  logic               sync_old;
  logic               edge_seen;
  logic [7:0]         settle_cnt;
  logic [31:0]        win_cnt;
  logic [1:0]         drain_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_nxt;
  logic               ovf_flag;
  logic               ovf_nxt;

  assign edge_seen = sync_q2 & ~sync_old;

  // Next counter value is also what DONE captures, so the final DRAIN cycle's edge is not lost.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_flag;
    if ((state == RUN || state == DRAIN) && edge_seen) begin
      if (&edge_cnt) ovf_nxt = 1'b1;
      else           edge_nxt = edge_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      sync_old   <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      drain_cnt  <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      a_input    <= '0;
      b_input    <= '0;
      ring_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      sync_q1  <= chain_out;
      sync_q2  <= sync_q1;
      sync_old <= sync_q2;
      edge_cnt <= edge_nxt;
      ovf_flag <= ovf_nxt;
      done     <= 1'b0;

      if (state != IDLE && !active) begin
        // Abort: results from the previous completed run stay visible.
        state   <= IDLE;
        ring_en <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && active) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            a_input    <= cfg_a;
            b_input    <= cfg_b;
            win_cnt    <= cfg_window;
            settle_cnt <= SETTLE_LAST;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == 8'd0) begin
              if (win_cnt == 32'd0) begin
                state     <= DRAIN;
                drain_cnt <= 2'd2;
              end else begin
                state   <= RUN;
                ring_en <= 1'b1;
              end
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end
          RUN: begin
            if (win_cnt == 32'd1) begin
              state     <= DRAIN;
              ring_en   <= 1'b0;
              drain_cnt <= 2'd2;
            end else begin
              win_cnt <= win_cnt - 32'd1;
            end
          end
          DRAIN: begin
            if (drain_cnt == 2'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              count    <= edge_nxt;
              overflow <= ovf_nxt;
            end else begin
              drain_cnt <= drain_cnt - 2'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            ring_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer: table of measurement runs plus abort and reset sequences.
module tb_adder_measure_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        active;
  logic        start;
  logic [31:0] cfg_a;
  logic [31:0] cfg_b;
  logic [31:0] cfg_window;
  logic        chain_out;

  logic [31:0] a_input, b_input;
  logic        ring_en, busy, done, overflow;
  logic [31:0] count;

  logic [31:0] a_input4, b_input4;
  logic        ring_en4, busy4, done4, overflow4;
  logic [3:0]  count4;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  adder_measure_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .active(active), .start(start),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window), .chain_out(chain_out),
    .a_input(a_input), .b_input(b_input), .ring_en(ring_en), .busy(busy),
    .done(done), .count(count), .overflow(overflow)
  );

  adder_measure_sequencer #(.SETTLE_CYCLES(4), .COUNT_W(4)) dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .active(active), .start(start),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window), .chain_out(chain_out),
    .a_input(a_input4), .b_input(b_input4), .ring_en(ring_en4), .busy(busy4),
    .done(done4), .count(count4), .overflow(overflow4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] win;
    int          npulse;
    logic        spam;
    int          exp_done;
    int          ring_first;
    int          ring_last;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    logic        exp_ovf4;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses are two cycles high, one low, starting in cycle 7 after the start edge.
  function automatic logic pulse_at(input int j, input int npulse);
    return (j >= 7) && (j < 7 + 3 * npulse) && (((j - 7) % 3) != 2);
  endfunction

  task automatic run_row(input int idx, input vec_t v);
    int   done_at;
    int   ring_bad;
    logic exp_ring;
    done_at  = -1;
    ring_bad = 0;
    cfg_a      = v.a;
    cfg_b      = v.b;
    cfg_window = v.win;
    start      = 1'b1;
    for (int j = 1; j <= 150; j++) begin
      step();
      start     = 1'b0;
      chain_out = pulse_at(j, v.npulse);
      if (j == 1) check($sformatf("row%0d_busy_load", idx), busy, 1);
      if (j == 2) begin
        check($sformatf("row%0d_a_input", idx), a_input, v.a);
        check($sformatf("row%0d_b_input", idx), b_input, v.b);
      end
      if (v.spam && (j == 3 || j == v.exp_done - 2)) start = 1'b1;
      exp_ring = (v.ring_first != 0) && (j >= v.ring_first) && (j <= v.ring_last);
      if (ring_en !== exp_ring) ring_bad++;
      if (done) begin
        done_at = j;
        start   = v.spam;
        break;
      end
    end
    check($sformatf("row%0d_done_cycle", idx), done_at, v.exp_done);
    check($sformatf("row%0d_ring_en_window", idx), ring_bad, 0);
    check($sformatf("row%0d_count", idx), count, v.exp_cnt);
    check($sformatf("row%0d_overflow", idx), overflow, 0);
    check($sformatf("row%0d_count4", idx), count4, v.exp_cnt4);
    check($sformatf("row%0d_overflow4", idx), overflow4, v.exp_ovf4);
    step();
    start = 1'b0;
    check($sformatf("row%0d_idle_after_done", idx), {busy, done}, 2'b00);
    step();
    check($sformatf("row%0d_still_idle", idx), busy, 0);
  endtask

  initial begin
    int saw_done;
    vecs[0] = '{32'h0000FFFF, 32'h1,        32'd10, 3,  1'b0, 19, 6, 15, 32'd3,  4'd3,  1'b0};
    vecs[1] = '{32'h11111111, 32'h22222222, 32'd0,  0,  1'b1, 9,  0, 0,  32'd0,  4'd0,  1'b0};
    vecs[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'd70, 20, 1'b1, 79, 6, 75, 32'd20, 4'd15, 1'b1};
    vecs[3] = '{32'h0000FFFF, 32'h1,        32'd10, 3,  1'b0, 19, 6, 15, 32'd3,  4'd3,  1'b0};
    vecs[4] = '{32'h0,        32'h0,        32'd1,  0,  1'b0, 10, 6, 6,  32'd0,  4'd0,  1'b0};
    vecs[5] = '{32'hDEADBEEF, 32'h12345678, 32'd5,  1,  1'b0, 14, 6, 10, 32'd1,  4'd1,  1'b0};

    wb_rst_i = 1'b1; active = 1'b1; start = 1'b0; chain_out = 1'b0;
    cfg_a = 32'h0; cfg_b = 32'h0; cfg_window = 32'h0;
    step();
    step();
    check("reset_a_input", a_input, 0);
    check("reset_b_input", b_input, 0);
    check("reset_count", count, 0);
    check("reset_flags", {ring_en, busy, done, overflow}, 4'b0000);
    wb_rst_i = 1'b0;
    step();
    check("idle_no_start", busy, 0);

    for (int i = 0; i < 6; i++) run_row(i, vecs[i]);

    // Abort by dropping active in the third RUN cycle; last result must survive.
    cfg_a = 32'h0000FFFF; cfg_b = 32'h1; cfg_window = 32'd10;
    start = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      start = 1'b0;
    end
    check("abort_ring_before", ring_en, 1);
    active = 1'b0;
    step();
    check("abort_ring_off", ring_en, 0);
    check("abort_busy_off", busy, 0);
    active   = 1'b1;
    saw_done = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_count_kept", count, 1);
    check("abort_count4_kept", count4, 1);

    // Reset in the middle of RUN.
    start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      start = 1'b0;
    end
    check("midrst_running", ring_en, 1);
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    check("midrst_state", {ring_en, busy, done, overflow}, 4'b0000);
    check("midrst_count", count, 0);
    check("midrst_a_input", a_input, 0);
    saw_done = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (done) saw_done++;
    end
    check("midrst_no_done", saw_done, 0);

    // Reset and start in the same cycle.
    wb_rst_i = 1'b1; start = 1'b1;
    step();
    check("rst_start_busy", busy, 0);
    wb_rst_i = 1'b0; start = 1'b0;
    step();
    check("rst_start_idle", {busy, done, ring_en}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
